dmem_arbiter: RTL

- Sole owner of the single-port data memory. Shares it between the pipeline MEM stage (CPU port) and a debug/dump port used by benches and the loader.
- Sequences sub-word stores (sb/sh) as read-modify-write on a word-wide memory.
- Performs sub-word load extraction and extension for lb/lbu/lh/lhu.
- Drives a stall to the pipeline while a CPU access is in flight.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/byte_lane_unit.sv | 41 ++++
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, port ids and
// the sequencing state machine states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RESP   = 3'd2,
    RMW_WR = 3'd3,
    WR     = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Reserved size or an address not naturally aligned for its size.
  function automatic logic align_err(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU port, debug port and single-port memory signals.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
  parameter int AW        = 32,
  parameter int MEM_WORDS = 1024
) ();

  localparam int IW = $clog2(MEM_WORDS);

  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_size;
  logic          cpu_unsigned;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ack;
  logic          cpu_err;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;
  logic [31:0]   dbg_rdata;
  logic          dbg_ack;

  logic          mem_en;
  logic          mem_we;
  logic [IW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/byte_lane_unit.sv
// Little-endian lane steering: merges sub-word store data into an old word
// and extracts/extends sub-word load values from it.
module byte_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store merge: only the addressed lane changes, other bytes are preserved.
  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8]     = new_data_i[7:0];
      SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = new_data_i[15:0];
      SZ_WORD: merged_o = new_data_i;
      default: merged_o = old_word_i;
    endcase
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    byte_s = old_word_i[{lane_i, 3'b000} +: 8];
    half_s = old_word_i[{lane_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: load_o = uns_i ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      SZ_HALF: load_o = uns_i ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      SZ_WORD: load_o = old_word_i;
      default: load_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin owner of the single-port data memory shared by the CPU MEM
// stage and the debug port; sequences sub-word stores as read-modify-write.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int           IW         = $clog2(MEM_WORDS);
  localparam logic [AW:0]  ADDR_LIMIT = (AW+1)'(MEM_WORDS * 4);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic          uns_q, uns_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    lane_q, lane_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          grant_cpu_s, grant_dbg_s;
  logic          sel_we_s, sel_uns_s, sel_err_s;
  logic [1:0]    sel_size_s;
  logic [AW-1:0] sel_addr_s;
  logic [31:0]   sel_wdata_s;
  logic [31:0]   merged_s, load_s;
  logic          ack_s, err_s, cpu_ack_s;
  logic [31:0]   rdata_s;

  byte_lane_unit u_lane (
    .size_i     (size_q),
    .uns_i      (uns_q),
    .lane_i     (lane_q),
    .old_word_i (bus.mem_rdata),
    .new_data_i (wdata_q),
    .merged_o   (merged_s),
    .load_o     (load_s)
  );

  // Grant selection, acceptance decode and next-state computation.
  always_comb begin
    grant_cpu_s = bus.cpu_req & (~bus.dbg_req | (last_grant_q == PORT_DBG));
    grant_dbg_s = bus.dbg_req & ~grant_cpu_s;
    if (grant_cpu_s) begin
      sel_we_s    = bus.cpu_we;
      sel_size_s  = bus.cpu_size;
      sel_uns_s   = bus.cpu_unsigned;
      sel_addr_s  = bus.cpu_addr;
      sel_wdata_s = bus.cpu_wdata;
    end else begin
      // Debug accesses are always whole words; the low address bits are dropped.
      sel_we_s    = bus.dbg_we;
      sel_size_s  = SZ_WORD;
      sel_uns_s   = 1'b0;
      sel_addr_s  = {bus.dbg_addr[AW-1:2], 2'b00};
      sel_wdata_s = bus.dbg_wdata;
    end
    sel_err_s = align_err(sel_size_s, sel_addr_s[1:0]) | ({1'b0, sel_addr_s} >= ADDR_LIMIT);

    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    uns_d        = uns_q;
    size_d       = size_q;
    lane_d       = lane_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_cpu_s | grant_dbg_s) begin
          owner_d      = grant_cpu_s ? PORT_CPU : PORT_DBG;
          last_grant_d = grant_cpu_s ? PORT_CPU : PORT_DBG;
          we_d         = sel_we_s;
          uns_d        = sel_uns_s;
          size_d       = sel_size_s;
          lane_d       = sel_addr_s[1:0];
          idx_d        = sel_addr_s[IW+1:2];
          wdata_d      = sel_wdata_s;
          if (sel_err_s) begin
            state_d = ERR;
          end else if (sel_we_s && (sel_size_s == SZ_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD:                    state_d = we_q ? RMW_WR : RESP;
      RESP, RMW_WR, WR, ERR: state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // State and request latch; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= PORT_CPU;
      last_grant_q <= PORT_DBG;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= SZ_BYTE;
      lane_q       <= 2'b00;
      idx_q        <= {IW{1'b0}};
      wdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
    end
  end

  // Memory and response outputs decoded from state and the latched request.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {IW{1'b0}};
    bus.mem_wdata = 32'd0;
    ack_s         = 1'b0;
    err_s         = 1'b0;
    rdata_s       = 32'd0;
    case (state_q)
      RD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = idx_q;
      end
      RESP: begin
        ack_s   = 1'b1;
        rdata_s = (owner_q == PORT_CPU) ? load_s : bus.mem_rdata;
      end
      RMW_WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = idx_q;
        bus.mem_wdata = merged_s;
        ack_s         = 1'b1;
      end
      WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = idx_q;
        bus.mem_wdata = wdata_q;
        ack_s         = 1'b1;
      end
      ERR: begin
        ack_s = 1'b1;
        err_s = 1'b1;
      end
      default: ack_s = 1'b0;
    endcase
    cpu_ack_s     = ack_s & (owner_q == PORT_CPU);
    bus.cpu_ack   = cpu_ack_s;
    bus.cpu_err   = err_s & (owner_q == PORT_CPU);
    bus.cpu_rdata = (owner_q == PORT_CPU) ? rdata_s : 32'd0;
    bus.dbg_ack   = ack_s & (owner_q == PORT_DBG);
    bus.dbg_rdata = (owner_q == PORT_DBG) ? rdata_s : 32'd0;
    bus.cpu_stall = bus.cpu_req & ~cpu_ack_s;
  end

endmodule
